// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control slice: sizing and FSM state encoding.
package fifo_pkg;

  localparam int DEPTH = 4;          // number of FIFO entries, power of two
  localparam int PTR_W = 2;          // log2(DEPTH)
  localparam int CNT_W = PTR_W + 1;  // occupancy 0..DEPTH

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PARTIAL = 2'b01,
    FULL    = 2'b10
  } fifo_state_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake/status bundle between the FIFO top level and fifo_ctrl.
interface fifo_ctrl_if;
  import fifo_pkg::*;

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] write_ptr;
  logic [PTR_W-1:0] read_ptr;
  logic             data_in_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             data_out_valid;
  logic [CNT_W-1:0] count;
  logic             err;

  // Requester side: issues push/pop, observes pointers and status.
  modport master (
    output push, pop,
    input  write_ptr, read_ptr, data_in_valid, fifo_full,
    input  fifo_empty, data_out_valid, count, err
  );

  // Controller side: consumes push/pop, owns pointers and status.
  modport slave (
    input  push, pop,
    output write_ptr, read_ptr, data_in_valid, fifo_full,
    output fifo_empty, data_out_valid, count, err
  );

endinterface

// File: rtl/ptr_ctr.sv
// Wrapping pointer counter; wraps naturally because DEPTH is a power of two.
module ptr_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,     // asynchronous, active-low
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  // Advance by one on enable, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = ptr_q + W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= {W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control: pointers, occupancy, full/empty state and error pulse.
// Sizing comes from fifo_pkg. Acceptance is judged on the registered
// status flags only, so pop never combinationally affects push acceptance.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,   // asynchronous, active-low
  fifo_ctrl_if.slave  bus
);

  fifo_state_e      state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_q;
  logic             err_d;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;

  // Status flags are decoded from the state register, not from pointers.
  assign full_s    = (state_q == FULL);
  assign empty_s   = (state_q == EMPTY);
  assign push_ok_s = bus.push & ~full_s;
  assign pop_ok_s  = bus.pop  & ~empty_s;

  // Next occupancy and error pulse from the accepted/rejected requests.
  always_comb begin
    count_d = count_q;
    err_d   = (bus.push & full_s) | (bus.pop & empty_s);
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy FSM with registered count and error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      count_q <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      case (state_q)
        EMPTY: begin
          if (push_ok_s) begin
            state_q <= PARTIAL;
          end else begin
            state_q <= EMPTY;
          end
        end
        PARTIAL: begin
          if (count_d == CNT_W'(DEPTH)) begin
            state_q <= FULL;
          end else if (count_d == {CNT_W{1'b0}}) begin
            state_q <= EMPTY;
          end else begin
            state_q <= PARTIAL;
          end
        end
        FULL: begin
          if (pop_ok_s) begin
            state_q <= PARTIAL;
          end else begin
            state_q <= FULL;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  ptr_ctr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (push_ok_s),
    .ptr_o (wr_ptr_s)
  );

  ptr_ctr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pop_ok_s),
    .ptr_o (rd_ptr_s)
  );

  assign bus.write_ptr      = wr_ptr_s;
  assign bus.read_ptr       = rd_ptr_s;
  assign bus.data_in_valid  = push_ok_s;
  assign bus.fifo_full      = full_s;
  assign bus.fifo_empty     = empty_s;
  assign bus.data_out_valid = ~empty_s;
  assign bus.count          = count_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus a random soak,
// all compared against an occupancy-level reference model.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic clk;
  logic rst;

  fifo_ctrl_if bus ();

  fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entries held, slot indices, pending error pulse.
  int m_count;
  int m_wr;
  int m_rd;
  int m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wr    = 0;
    m_rd    = 0;
    m_err   = 0;
  endtask

  task automatic check_state(input string tag);
    logic [PTR_W-1:0] diff;
    chk({tag, ".write_ptr"}, bus.write_ptr, m_wr);
    chk({tag, ".read_ptr"},  bus.read_ptr,  m_rd);
    chk({tag, ".count"},     bus.count,     m_count);
    chk({tag, ".full"},      bus.fifo_full,  (m_count == DEPTH) ? 1 : 0);
    chk({tag, ".empty"},     bus.fifo_empty, (m_count == 0) ? 1 : 0);
    chk({tag, ".err"},       bus.err,        m_err);
    diff = bus.write_ptr - bus.read_ptr;
    chk({tag, ".ptr_inv"},   diff, bus.count[PTR_W-1:0]);
  endtask

  // One clock: drive at negedge, check comb outputs, advance model, check state.
  task automatic cycle(input string tag, input logic p, input logic q);
    int pok;
    int qok;
    bus.push = p;
    bus.pop  = q;
    #1;
    chk({tag, ".data_in_valid"},  bus.data_in_valid,  (p && m_count < DEPTH) ? 1 : 0);
    chk({tag, ".data_out_valid"}, bus.data_out_valid, (m_count > 0) ? 1 : 0);
    @(posedge clk);
    pok = (p && m_count < DEPTH) ? 1 : 0;
    qok = (q && m_count > 0) ? 1 : 0;
    m_err   = ((p && !pok) || (q && !qok)) ? 1 : 0;
    m_count = m_count + pok - qok;
    m_wr    = (m_wr + pok) % DEPTH;
    m_rd    = (m_rd + qok) % DEPTH;
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst      = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset mid-stream after three pushes, applied between edges.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 1'b0);
    chk("pre_rst.count3", bus.count, 3);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // Fill from reset, then a rejected fifth push.
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill", 1'b1, 1'b0);
      chk("fill.wp_seq", bus.write_ptr, (i + 1) % 4);
      chk("fill.cnt_seq", bus.count, i + 1);
    end
    chk("fill.full", bus.fifo_full, 1);
    cycle("push_full", 1'b1, 1'b0);
    chk("push_full.err", bus.err, 1);

    // Drain with wrap, then a rejected fifth pop.
    for (int i = 0; i < DEPTH; i++) begin
      cycle("drain", 1'b0, 1'b1);
      chk("drain.rp_seq", bus.read_ptr, (i + 1) % 4);
    end
    chk("drain.empty", bus.fifo_empty, 1);
    cycle("pop_empty", 1'b0, 1'b1);
    chk("pop_empty.err", bus.err, 1);
    chk("pop_empty.rp", bus.read_ptr, 0);

    // Simultaneous push/pop while PARTIAL (count=2, wp=2, rp=0).
    cycle("part_fill", 1'b1, 1'b0);
    cycle("part_fill", 1'b1, 1'b0);
    cycle("part_both", 1'b1, 1'b1);
    chk("part_both.wp", bus.write_ptr, 3);
    chk("part_both.rp", bus.read_ptr, 1);
    chk("part_both.cnt", bus.count, 2);
    chk("part_both.err", bus.err, 0);

    // Simultaneous push/pop at EMPTY.
    cycle("to_empty", 1'b0, 1'b1);
    cycle("to_empty", 1'b0, 1'b1);
    cycle("empty_both", 1'b1, 1'b1);
    chk("empty_both.cnt", bus.count, 1);
    chk("empty_both.err", bus.err, 1);

    // Simultaneous push/pop at FULL.
    for (int i = 0; i < 3; i++) cycle("to_full", 1'b1, 1'b0);
    chk("to_full.full", bus.fifo_full, 1);
    cycle("full_both", 1'b1, 1'b1);
    chk("full_both.cnt", bus.count, 3);
    chk("full_both.err", bus.err, 1);

    // Random soak against the model.
    for (int i = 0; i < 10000; i++) begin
      cycle("soak", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
